stdp_synapse_array: RTL and testbench

- Parametrised pair-based STDP weight engine for NUM_SYN presynaptic inputs converging on one postsynaptic Izhikevich neuron.
- Keeps the timestep counter, per-synapse pre-spike ages, post-spike age and the weight memory.
- On each accepted timestep, scans all synapses serially, applies linear-window LTP/LTD and clamps each weight.
- Sits between the Izhikevich cores and the current-summing stage of coupled networks, replacing hard-wired coupling with a learned weight.

---
 rtl/stdp_synapse_array.sv | 218 +++++++++++++++++++++
 tb/tb_stdp_synapse_array.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stdp_synapse_array.sv
// -----------------------------------------------------------------------------
// stdp_synapse_array
//
// Pair-based STDP weight engine for NUM_SYN presynaptic inputs converging on a
// single postsynaptic neuron. Each accepted timestep latches the spike flags,
// then scans the synapses one per cycle. Each synapse gets a linear-window
// potentiation/depression, a clamp to [w_min, w_max], and an update of its
// spike age.
//
// Ports
//   clk          clock
//   rst          asynchronous active-low reset
//   apply        timestep strobe, accepted only while ready=1
//   enable_stdp  weight write-back enable for the timestep (latched on accept)
//   pre_spike    presynaptic spike flags for the timestep
//   post_spike   postsynaptic spike flag for the timestep
//   a_plus/a_minus   LTP/LTD amplitude at age 0 (signed Q fixed point)
//   m_plus/m_minus   LTP/LTD decay per timestep of age
//   w_min/w_max  weight clamp bounds
//   wr_en/wr_addr/wr_data  host weight write (IDLE only, stored unclamped)
//   rd_addr/rd_data        registered weight read, 1-cycle latency
//   ready        high in IDLE
//   done         one-cycle pulse when a scan completes
//   step_count   number of accepted timesteps (wraps)
//   rollover     one-cycle pulse when step_count wraps to 0
// -----------------------------------------------------------------------------
module stdp_synapse_array #(
  parameter int N       = 32,
  parameter int Q       = 16,
  parameter int NUM_SYN = 8,
  parameter int AGE_W   = 8,
  parameter int WINDOW  = 20,
  parameter int STEP_W  = 16,
  parameter logic [N-1:0] W_INIT = 'h0000_8000,
  localparam int ADDR_W = (NUM_SYN > 1) ? $clog2(NUM_SYN) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                apply,
  input  logic                enable_stdp,
  input  logic [NUM_SYN-1:0]  pre_spike,
  input  logic                post_spike,
  input  logic signed [N-1:0] a_plus,
  input  logic signed [N-1:0] a_minus,
  input  logic signed [N-1:0] m_plus,
  input  logic signed [N-1:0] m_minus,
  input  logic signed [N-1:0] w_min,
  input  logic signed [N-1:0] w_max,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic signed [N-1:0] wr_data,
  output logic signed [N-1:0] rd_data,
  output logic                ready,
  output logic                done,
  output logic [STEP_W-1:0]   step_count,
  output logic                rollover
);

  if (WINDOW >= (1 << AGE_W) - 1 || Q >= N || NUM_SYN < 1 || AGE_W >= N) begin : g_param_check
    $error("stdp_synapse_array: inconsistent parameters");
  end

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // All-ones age marks "no spike seen recently"; it is always outside the window.
  localparam logic [AGE_W-1:0]  AGE_SAT  = '1;
  localparam logic [AGE_W-1:0]  AGE_WIN  = AGE_W'(WINDOW);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_SYN - 1);

  logic [1:0]                state;
  logic [ADDR_W-1:0]         k;
  logic [NUM_SYN-1:0]        pre_lat;
  logic                      post_lat;
  logic                      en_lat;
  logic [AGE_W-1:0]          pre_age [NUM_SYN];
  logic [AGE_W-1:0]          post_age;
  logic signed [N-1:0]       weight [NUM_SYN];

  logic                      last_k;
  logic signed [N-1:0]       w_cur;
  logic signed [N-1:0]       ltp;
  logic signed [N-1:0]       ltd;
  logic signed [N-1:0]       w_new;

  // Linear decay of an amplitude with age; the product keeps the low N bits
  // and a negative result means the pair is too far apart to contribute.
  function automatic logic signed [N-1:0] decay_amp(
    input logic signed [N-1:0] amp,
    input logic signed [N-1:0] decay,
    input logic [AGE_W-1:0]    age
  );
    logic signed [N-1:0] age_s;
    logic signed [N-1:0] prod;
    logic signed [N-1:0] diff;
    age_s = $signed(N'(age));
    prod  = decay * age_s;
    diff  = amp - prod;
    return diff[N-1] ? '0 : diff;
  endfunction

  // Two guard bits hold w + ltp - ltd exactly before the clamp.
  function automatic logic signed [N-1:0] clamp_sum(
    input logic signed [N-1:0] w,
    input logic signed [N-1:0] up,
    input logic signed [N-1:0] dn,
    input logic signed [N-1:0] lo,
    input logic signed [N-1:0] hi
  );
    logic signed [N+1:0] sum;
    sum = (N+2)'(w) + (N+2)'(up) - (N+2)'(dn);
    if (sum > (N+2)'(hi)) begin
      return hi;
    end else if (sum < (N+2)'(lo)) begin
      return lo;
    end
    return $signed(sum[N-1:0]);
  endfunction

  function automatic logic [AGE_W-1:0] age_next(
    input logic             spike,
    input logic [AGE_W-1:0] age
  );
    if (spike) begin
      return AGE_W'(1);
    end else if (age == AGE_SAT) begin
      return age;
    end
    return age + 1'b1;
  endfunction

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < (ADDR_W+1)'(NUM_SYN);
  endfunction

  assign ready  = (state == S_IDLE);
  assign done   = (state == S_DONE);
  assign last_k = (k == LAST_IDX);

  // Scan datapath for synapse k. Ages are the pre-timestep values, so a pre and
  // post spike in the same timestep never pair with each other.
  always_comb begin
    w_cur = weight[k];
    ltp   = '0;
    ltd   = '0;
    if (post_lat && (pre_age[k] < AGE_WIN)) begin
      ltp = decay_amp(a_plus, m_plus, pre_age[k]);
    end
    if (pre_lat[k] && (post_age < AGE_WIN)) begin
      ltd = decay_amp(a_minus, m_minus, post_age);
    end
    w_new = clamp_sum(w_cur, ltp, ltd, w_min, w_max);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      k          <= '0;
      pre_lat    <= '0;
      post_lat   <= 1'b0;
      en_lat     <= 1'b0;
      step_count <= '0;
      rollover   <= 1'b0;
      rd_data    <= '0;
      post_age   <= AGE_SAT;
      for (int i = 0; i < NUM_SYN; i++) begin
        pre_age[i] <= AGE_SAT;
        weight[i]  <= W_INIT;
      end
    end else begin
      rollover <= 1'b0;
      // Nonblocking read of the array returns the pre-write value when the
      // scan updates the same address this cycle.
      rd_data  <= addr_ok(rd_addr) ? weight[rd_addr] : '0;

      case (state)
        S_IDLE: begin
          if (apply) begin
            pre_lat    <= pre_spike;
            post_lat   <= post_spike;
            en_lat     <= enable_stdp;
            step_count <= step_count + 1'b1;
            rollover   <= &step_count;
            k          <= '0;
            state      <= S_SCAN;
          end else if (wr_en && addr_ok(wr_addr)) begin
            weight[wr_addr] <= wr_data;
          end
        end

        S_SCAN: begin
          pre_age[k] <= age_next(pre_lat[k], pre_age[k]);
          if (en_lat) begin
            weight[k] <= w_new;
          end
          // post_age must stay at its old value until every synapse has used it.
          if (last_k) begin
            post_age <= age_next(post_lat, post_age);
            state    <= S_DONE;
          end else begin
            k <= k + 1'b1;
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stdp_synapse_array.sv
module tb_stdp_synapse_array;

  localparam int N       = 32;
  localparam int NUM_SYN = 8;
  localparam int AGE_W   = 8;
  localparam int WINDOW  = 20;
  localparam int STEP_W  = 4;
  localparam int AGE_MAX = (1 << AGE_W) - 1;

  logic                clk;
  logic                rst;
  logic                apply;
  logic                enable_stdp;
  logic [NUM_SYN-1:0]  pre_spike;
  logic                post_spike;
  logic signed [N-1:0] a_plus, a_minus, m_plus, m_minus;
  logic signed [N-1:0] w_min, w_max;
  logic                wr_en;
  logic [2:0]          wr_addr, rd_addr;
  logic signed [N-1:0] wr_data;
  logic signed [N-1:0] rd_data;
  logic                ready, done, rollover;
  logic [STEP_W-1:0]   step_count;

  stdp_synapse_array #(
    .N(N), .Q(16), .NUM_SYN(NUM_SYN), .AGE_W(AGE_W), .WINDOW(WINDOW),
    .STEP_W(STEP_W), .W_INIT(32'h0000_8000)
  ) dut (
    .clk(clk), .rst(rst), .apply(apply), .enable_stdp(enable_stdp),
    .pre_spike(pre_spike), .post_spike(post_spike),
    .a_plus(a_plus), .a_minus(a_minus), .m_plus(m_plus), .m_minus(m_minus),
    .w_min(w_min), .w_max(w_max),
    .wr_en(wr_en), .wr_addr(wr_addr), .rd_addr(rd_addr), .wr_data(wr_data),
    .rd_data(rd_data), .ready(ready), .done(done),
    .step_count(step_count), .rollover(rollover)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: weights, ages in timesteps since last spike, step count.
  int mw [NUM_SYN];
  int mpre [NUM_SYN];
  int mpost;
  int mstep;
  int roll_seen;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_SYN; i++) begin
      mw[i]   = 32'h0000_8000;
      mpre[i] = AGE_MAX;
    end
    mpost = AGE_MAX;
    mstep = 0;
  endtask

  task automatic model_step(input logic [NUM_SYN-1:0] pre, input logic post, input logic en);
    int     ltp, ltd;
    longint s;
    for (int i = 0; i < NUM_SYN; i++) begin
      ltp = 0;
      ltd = 0;
      if (post && mpre[i] < WINDOW) begin
        ltp = int'(a_plus) - int'(m_plus) * mpre[i];
        if (ltp < 0) ltp = 0;
      end
      if (pre[i] && mpost < WINDOW) begin
        ltd = int'(a_minus) - int'(m_minus) * mpost;
        if (ltd < 0) ltd = 0;
      end
      s = longint'(mw[i]) + longint'(ltp) - longint'(ltd);
      if (s > longint'(w_max)) s = longint'(w_max);
      else if (s < longint'(w_min)) s = longint'(w_min);
      if (en) mw[i] = int'(s);
    end
    for (int i = 0; i < NUM_SYN; i++)
      mpre[i] = pre[i] ? 1 : ((mpre[i] >= AGE_MAX) ? AGE_MAX : mpre[i] + 1);
    mpost = post ? 1 : ((mpost >= AGE_MAX) ? AGE_MAX : mpost + 1);
    mstep = (mstep + 1) % (1 << STEP_W);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    model_reset();
    tick();
  endtask

  // One timestep; with extra_apply the strobe stays high through the scan.
  task automatic do_step(input logic [NUM_SYN-1:0] pre, input logic post, input logic en,
                         input bit extra_apply);
    int cnt;
    bit exp_roll;
    cnt = 0;
    while (!ready && cnt < 100) begin
      tick();
      cnt++;
    end
    check("ready_before_apply", 32'(ready), 32'd1);
    apply       = 1'b1;
    pre_spike   = pre;
    post_spike  = post;
    enable_stdp = en;
    exp_roll    = (mstep == (1 << STEP_W) - 1);
    model_step(pre, post, en);
    tick();
    check("rollover", 32'(rollover), 32'(exp_roll));
    if (rollover) roll_seen++;
    check("step_count", 32'(step_count), 32'(mstep));
    if (extra_apply) begin
      pre_spike  = '1;
      post_spike = 1'b1;
    end else begin
      apply = 1'b0;
    end
    cnt = 1;
    while (!done && cnt < 50) begin
      tick();
      cnt++;
      if (cnt == 2) check("rollover_pulse", 32'(rollover), 32'd0);
    end
    apply      = 1'b0;
    pre_spike  = '0;
    post_spike = 1'b0;
    check("done_latency", 32'(cnt), 32'(NUM_SYN + 1));
    tick();
    check("done_pulse", 32'(done), 32'd0);
    check("step_count_after", 32'(step_count), 32'(mstep));
  endtask

  task automatic idle_steps(input int n, input logic en);
    for (int i = 0; i < n; i++) do_step('0, 1'b0, en, 1'b0);
  endtask

  task automatic read_w(input int a, output logic [31:0] v);
    rd_addr = 3'(a);
    tick();
    v = rd_data;
  endtask

  task automatic check_weights(input string tag);
    logic [31:0] v;
    for (int i = 0; i < NUM_SYN; i++) begin
      read_w(i, v);
      check($sformatf("%s_w%0d", tag, i), v, mw[i]);
    end
  endtask

  task automatic host_write(input int a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = 3'(a);
    wr_data = d;
    tick();
    wr_en = 1'b0;
    mw[a] = int'(d);
  endtask

  task automatic set_default_params();
    a_plus  = 32'h0000_1000;
    m_plus  = 32'h0000_0100;
    a_minus = 32'h0000_1000;
    m_minus = 32'h0000_0100;
    w_min   = 32'h0000_0000;
    w_max   = 32'h0001_0000;
  endtask

  task automatic potentiation_seq(input logic en);
    do_step(8'h04, 1'b0, en, 1'b0);
    idle_steps(2, en);
    do_step(8'h00, 1'b1, en, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation timeout");
  end

  initial begin
    logic [31:0] v;
    logic [NUM_SYN-1:0] pr;
    rst = 1'b0; apply = 1'b0; enable_stdp = 1'b0; pre_spike = '0; post_spike = 1'b0;
    wr_en = 1'b0; wr_addr = '0; rd_addr = '0; wr_data = '0;
    roll_seen = 0;
    set_default_params();
    do_reset();

    // Reset state
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    check("reset_rollover", 32'(rollover), 32'd0);
    check("reset_step", 32'(step_count), 32'd0);
    check_weights("reset");

    // Potentiation: pre age 3 at the post spike -> 0x1000 - 3*0x100
    potentiation_seq(1'b1);
    read_w(2, v);
    check("ltp_w2", v, 32'h0000_8D00);
    check_weights("ltp");

    // Depression: post age 5 at the pre spike -> 0x1000 - 5*0x100
    do_reset();
    do_step(8'h00, 1'b1, 1'b1, 1'b0);
    idle_steps(4, 1'b1);
    do_step(8'h01, 1'b0, 1'b1, 1'b0);
    read_w(0, v);
    check("ltd_w0", v, 32'h0000_7500);
    check_weights("ltd");

    // Upper clamp
    do_reset();
    w_max = 32'h0000_8800;
    potentiation_seq(1'b1);
    read_w(2, v);
    check("clamp_w2", v, 32'h0000_8800);
    w_max = 32'h0001_0000;

    // Pair outside the window
    do_reset();
    do_step(8'h04, 1'b0, 1'b1, 1'b0);
    idle_steps(24, 1'b1);
    do_step(8'h00, 1'b1, 1'b1, 1'b0);
    read_w(2, v);
    check("window_w2", v, 32'h0000_8000);
    check_weights("window");

    // Simultaneous pre and post do not pair
    do_reset();
    do_step(8'h04, 1'b1, 1'b1, 1'b0);
    read_w(2, v);
    check("same_step_w2", v, 32'h0000_8000);

    // STDP disabled
    do_reset();
    potentiation_seq(1'b0);
    read_w(2, v);
    check("gated_w2", v, 32'h0000_8000);

    // apply held through the scan is ignored
    do_reset();
    do_step(8'h00, 1'b0, 1'b1, 1'b1);
    check("scan_apply_step", 32'(step_count), 32'd1);
    check_weights("scan_apply");

    // Rollover after 2^STEP_W accepted timesteps
    do_reset();
    roll_seen = 0;
    idle_steps(16, 1'b1);
    check("roll_count", 32'(roll_seen), 32'd1);
    check("roll_step", 32'(step_count), 32'd0);

    // Reset in the middle of a scan
    do_reset();
    host_write(1, 32'h1234_5678);
    read_w(1, v);
    check("host_write_w1", v, 32'h1234_5678);
    apply = 1'b1; pre_spike = '1; post_spike = 1'b1; enable_stdp = 1'b1;
    tick();
    apply = 1'b0;
    tick();
    tick();
    check("mid_scan_busy", 32'(ready), 32'd0);
    rst = 1'b0;
    #1;
    check("mid_reset_ready", 32'(ready), 32'd1);
    check("mid_reset_step", 32'(step_count), 32'd0);
    tick();
    rst = 1'b1;
    pre_spike = '0; post_spike = 1'b0;
    model_reset();
    tick();
    check_weights("mid_reset");

    // Randomized timesteps against the model
    do_reset();
    a_plus  = 32'($urandom_range(32'h2000));
    m_plus  = 32'($urandom_range(32'h0400));
    a_minus = 32'($urandom_range(32'h2000));
    m_minus = 32'($urandom_range(32'h0400));
    w_min   = 32'h0000_4000;
    w_max   = 32'h0000_C000;
    for (int i = 0; i < NUM_SYN; i++)
      host_write(i, 32'($urandom_range(32'hE000, 32'h2000)));
    check_weights("rand_init");
    for (int t = 0; t < 40; t++) begin
      for (int b = 0; b < NUM_SYN; b++) pr[b] = ($urandom_range(3) == 0);
      do_step(pr, ($urandom_range(2) == 0), ($urandom_range(7) != 0), 1'b0);
      if (t % 10 == 9) check_weights($sformatf("rand_t%0d", t));
    end
    set_default_params();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
